// File: rtl/sysid_reader.sv
// Avalon-MM read master: fetches system ID (word 0) and build timestamp (word 1) and checks both.
// Define SYSID_READER_TIMEOUT_EN to compile in the per-read timeout, retry and BACKOFF logic.
module sysid_reader #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1385403304,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_bad_cfg
      $error("sysid_reader: TIMEOUT_CYCLES must be 1..255, MAX_RETRIES 0..7");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      RD_TS,
`ifdef SYSID_READER_TIMEOUT_EN
      BACKOFF,
`endif
      FINISH
   } state_t;

   state_t state, state_nx;
   logic   cap_id, cap_ts;
   logic   id_got;   // word 0 captured during the current run

`ifdef SYSID_READER_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic [2:0] retry_cnt;
   logic       ret_ts;
   logic       retry, give_up;
`endif

   // Outputs decode straight from state so avm_read drops asynchronously with reset.
   assign avm_read    = (state == RD_ID) || (state == RD_TS);
   assign avm_address = (state == RD_TS);
   assign busy        = (state != IDLE);
   assign done        = (state == FINISH);

   always_comb begin
      state_nx = state;
      cap_id   = 1'b0;
      cap_ts   = 1'b0;
`ifdef SYSID_READER_TIMEOUT_EN
      retry    = 1'b0;
      give_up  = 1'b0;
`endif
      case (state)
         IDLE: if (start) state_nx = RD_ID;
         RD_ID, RD_TS: begin
            if (!avm_waitrequest) begin
               cap_id   = (state == RD_ID);
               cap_ts   = (state == RD_TS);
               state_nx = (state == RD_ID) ? RD_TS : FINISH;
            end
`ifdef SYSID_READER_TIMEOUT_EN
            else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
               if (retry_cnt < 3'(MAX_RETRIES)) begin
                  retry    = 1'b1;
                  state_nx = BACKOFF;
               end else begin
                  give_up  = 1'b1;
                  state_nx = FINISH;
               end
            end
`endif
         end
`ifdef SYSID_READER_TIMEOUT_EN
         BACKOFF: state_nx = ret_ts ? RD_TS : RD_ID;
`endif
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         id_value <= '0;
         ts_value <= '0;
         id_match <= 1'b0;
         ts_match <= 1'b0;
         id_got   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            id_match <= 1'b0;
            ts_match <= 1'b0;
            id_got   <= 1'b0;
         end
         if (cap_id) begin
            id_value <= avm_readdata;
            id_got   <= 1'b1;
         end
         // Timestamp is compared from the bus, it lands in ts_value on the same edge.
         if (cap_ts) begin
            ts_value <= avm_readdata;
            id_match <= id_got && (id_value == EXPECTED_ID);
            ts_match <= (avm_readdata == EXPECTED_TS);
         end
`ifdef SYSID_READER_TIMEOUT_EN
         if (give_up) id_match <= id_got && (id_value == EXPECTED_ID);
`endif
      end
   end

`ifdef SYSID_READER_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt    <= '0;
         retry_cnt   <= '0;
         ret_ts      <= 1'b0;
         timeout_err <= 1'b0;
      end else if (state == IDLE && start) begin
         wait_cnt    <= '0;
         retry_cnt   <= '0;
         timeout_err <= 1'b0;
      end else if (cap_id) begin
         wait_cnt  <= '0;
         retry_cnt <= '0;
      end else if (retry) begin
         retry_cnt <= retry_cnt + 3'd1;
         wait_cnt  <= '0;
         ret_ts    <= (state == RD_TS);
      end else if (give_up) begin
         timeout_err <= 1'b1;
      end else if (avm_read && avm_waitrequest) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_reader.sv
// Scoreboard bench for sysid_reader: a randomized slave model feeds the DUT, expectations are
// queued per start and checked by a monitor on each done pulse.
module tb_sysid_reader;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1385403304;
   localparam int TO = 6;
   localparam int MR = 1;

   logic        clock = 1'b0;
   logic        reset_n, start;
   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, id_match, ts_match, timeout_err;
   logic [31:0] id_value, ts_value;

   sysid_reader #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
      .id_match(id_match), .ts_match(ts_match), .timeout_err(timeout_err),
      .id_value(id_value), .ts_value(ts_value));

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] id, ts;
      bit idm, tsm, toe;
      int t0, lat, att, low;
      bit a1;
   } exp_t;

   exp_t q[$];
   int compared = 0, mismatched = 0;
   int cyc = 0;

   // slave configuration
   logic [31:0] sl_id = 0, sl_ts = 0;
   int  sl_waits = 0;
   bit  sl_stuck0 = 0;
   // model of the registered values
   logic [31:0] mod_id = 0, mod_ts = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Slave model and monitor share one negedge process so slave updates precede sampling.
   initial begin
      int  wcnt, att, low;
      bit  prev_read, prev_wr, prev_addr, a1, glitch, wr;
      exp_t e;
      wcnt = 0; att = 0; low = 0; prev_read = 0; prev_wr = 0; prev_addr = 0; a1 = 0; glitch = 0;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            att = 0; low = 0; a1 = 0; glitch = 0; prev_read = 0; prev_wr = 0; wcnt = 0;
         end else begin
            if (avm_read) begin
               wcnt = (prev_read && prev_wr) ? wcnt + 1 : 0;
               wr = (sl_stuck0 && !avm_address) || (wcnt < sl_waits);
               avm_readdata = wr ? $urandom : (avm_address ? sl_ts : sl_id);
            end else begin
               wcnt = 0;
               wr = 1'($urandom_range(0, 1));
               avm_readdata = $urandom;
            end
            avm_waitrequest = wr;
            if (busy && avm_read && !prev_read) att++;
            if (avm_read && avm_address) a1 = 1;
            if (busy && !avm_read && !done) low++;
            if (avm_read && prev_read && prev_wr && (avm_address != prev_addr)) glitch = 1;
            prev_read = avm_read; prev_wr = wr; prev_addr = avm_address;
            if (done) begin
               if (q.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("latency", cyc - e.t0, e.lat);
                  chk("id_value", id_value, e.id);
                  chk("ts_value", ts_value, e.ts);
                  chk("id_match", 32'(id_match), 32'(e.idm));
                  chk("ts_match", 32'(ts_match), 32'(e.tsm));
                  chk("timeout_err", 32'(timeout_err), 32'(e.toe));
                  chk("read_attempts", att, e.att);
                  chk("read_gap_cycles", low, e.low);
                  chk("addr1_issued", 32'(a1), 32'(e.a1));
                  chk("addr_stable", 32'(glitch), 32'd0);
                  chk("busy_at_done", 32'(busy), 32'd1);
               end
               att = 0; low = 0; a1 = 0; glitch = 0;
            end
         end
      end
   end

   task automatic wait_done(output bit ok);
      int k = 0;
      while (!done && k < 400) begin
         @(negedge clock);
         k++;
      end
      ok = done;
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [31:0] id, input logic [31:0] ts, input int w, input bit stuck, input bit extra);
      exp_t e;
      bit ok;
      int k;
      @(negedge clock);
      sl_id = id; sl_ts = ts; sl_waits = w; sl_stuck0 = stuck;
      if (stuck) begin
         e.id = mod_id; e.ts = mod_ts; e.idm = 0; e.tsm = 0; e.toe = 1;
         e.lat = 1 + (MR + 1) * TO + MR; e.att = MR + 1; e.low = MR; e.a1 = 0;
      end else begin
         mod_id = id; mod_ts = ts;
         e.id = id; e.ts = ts; e.idm = (id == EXP_ID); e.tsm = (ts == EXP_TS); e.toe = 0;
         e.lat = 3 + 2 * w; e.att = 1; e.low = 0; e.a1 = 1;
      end
      start = 1'b1;
      e.t0 = cyc;
      q.push_back(e);
      @(negedge clock);
      start = 1'b0;
      if (extra) begin
         k = 0;
         while (!(avm_read && avm_address) && k < 100) begin
            @(negedge clock);
            k++;
         end
         if (!(avm_read && avm_address)) chk("reach_rd_ts", 32'd0, 32'd1);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      wait_done(ok);
      if (extra && ok) begin
         start = 1'b1;           // lands in the FINISH cycle, must be dropped
         @(negedge clock);
         start = 1'b0;
      end
      repeat (4) @(negedge clock);
      chk("idle_after_run", 32'(busy), 32'd0);
   endtask

   initial begin
      start = 1'b0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_flags", 32'({avm_read, avm_address, busy, done, id_match, ts_match, timeout_err}), 32'd0);
      chk("rst_id_value", id_value, 32'd0);
      chk("rst_ts_value", ts_value, 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      run(EXP_ID, EXP_TS, 0, 0, 0);
      run(EXP_ID, 32'h12345678, 0, 0, 0);
      run(EXP_ID, EXP_TS, 5, 0, 0);
      run(EXP_ID, EXP_TS, 2, 0, 1);
`ifdef SYSID_READER_TIMEOUT_EN
      run(32'h0000dead, 32'h0000beef, 0, 1, 0);
`endif
      for (int i = 0; i < 12; i++) begin
         logic [31:0] rid, rts;
         rid = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom;
         rts = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom;
         run(rid, rts, $urandom_range(0, 5), 0, 0);
      end

      // reset during a stalled word-0 read
      @(negedge clock);
      sl_stuck0 = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("stalled_read_active", 32'({avm_read, avm_address}), 32'h2);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_flags", 32'({avm_read, avm_address, busy, done, id_match, ts_match, timeout_err}), 32'd0);
      chk("midrst_id_value", id_value, 32'd0);
      chk("midrst_ts_value", ts_value, 32'd0);
      mod_id = 0; mod_ts = 0;
      sl_stuck0 = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      run(32'h00c0ffee, EXP_TS, 1, 0, 0);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
